// File: rtl/sram_arb.sv
// Two-port arbiter/sequencer for the 512Kx16 image SRAM, with drained store dump.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module sram_arb #(
  parameter int AW = 19,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          store_req,
  output logic          store_done,
  output logic          sram_csn,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout,
  output logic          sram_store
);

  typedef enum logic [1:0] {ARB, DRAIN, STORE} state_e;

  state_e        state_q, state_d;
  logic          csn_q, csn_d, wen_q, wen_d, store_q, store_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] din_q, din_d;
  logic [1:0]    rd_vld_q, rd_vld_d, rd_id_q, rd_id_d;
  logic          g0, g1, acc, sel;
`ifdef SRAM_ARB_RR_EN
  logic          ptr_q, ptr_d;  // 1: m1 wins the next conflict
`endif

  always_comb begin
    state_d = state_q;
    store_d = 1'b0;
    g0      = 1'b0;
    g1      = 1'b0;
    case (state_q)
      ARB: begin
        // a pending dump blocks all grants so the command register can drain
        if (store_req) begin
          state_d = DRAIN;
        end else if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
          g0 = ~ptr_q;
          g1 = ptr_q;
`else
          g0 = 1'b1;
`endif
        end else begin
          g0 = m0_req;
          g1 = m1_req;
        end
      end
      DRAIN: begin
        if (csn_q) begin
          state_d = STORE;
          store_d = 1'b1;
        end
      end
      STORE:   state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  assign acc = g0 | g1;
  assign sel = g1;

  always_comb begin
    csn_d    = ~acc;
    wen_d    = acc & (sel ? m1_we : m0_we);
    a_d      = acc ? (sel ? m1_addr : m0_addr) : a_q;
    din_d    = acc ? (sel ? m1_wdata : m0_wdata) : din_q;
    rd_vld_d = {rd_vld_q[0], acc & ~wen_d};
    rd_id_d  = {rd_id_q[0], sel};
`ifdef SRAM_ARB_RR_EN
    ptr_d    = acc ? ~sel : ptr_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      csn_q    <= 1'b1;
      wen_q    <= 1'b0;
      a_q      <= '0;
      din_q    <= '0;
      store_q  <= 1'b0;
      rd_vld_q <= '0;
      rd_id_q  <= '0;
`ifdef SRAM_ARB_RR_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      csn_q    <= csn_d;
      wen_q    <= wen_d;
      a_q      <= a_d;
      din_q    <= din_d;
      store_q  <= store_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
`ifdef SRAM_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // grants are combinational, so mask them while reset is held
  assign m0_gnt     = g0 & ~rst;
  assign m1_gnt     = g1 & ~rst;
  assign m0_rvalid  = rd_vld_q[1] & ~rd_id_q[1];
  assign m1_rvalid  = rd_vld_q[1] & rd_id_q[1];
  assign m0_rdata   = m0_rvalid ? sram_dout : '0;
  assign m1_rdata   = m1_rvalid ? sram_dout : '0;
  assign sram_csn   = csn_q;
  assign sram_wen   = wen_q;
  assign sram_a     = a_q;
  assign sram_din   = din_q;
  assign sram_store = store_q;
  assign store_done = store_q;

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: behavioural SRAM, transaction-level reference model,
// directed scenarios followed by randomized traffic with store dumps.
module tb_sram_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, store_req;
  logic [18:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, store_done;
  logic [15:0] m0_rdata, m1_rdata;
  logic        sram_csn, sram_wen, sram_store;
  logic [18:0] sram_a;
  logic [15:0] sram_din, sram_dout, dump3;

  always #5 clk = ~clk;

  sram_arb dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .store_req(store_req), .store_done(store_done),
    .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_a(sram_a), .sram_din(sram_din),
    .sram_dout(sram_dout), .sram_store(sram_store)
  );

  // behavioural SRAM: synchronous access, dump snapshot of address 3
  logic [15:0] mem [0:524287];
  always @(posedge clk) begin
    if (!sram_csn) begin
      if (sram_wen) mem[sram_a] <= sram_din;
      else          sram_dout   <= mem[sram_a];
    end
    if (sram_store) dump3 <= mem[3];
  end

  // reference model state
  typedef struct { int due; logic p; logic [15:0] d; } rd_t;
  rd_t         rq[$];
  logic [15:0] gmem [0:524287];
  logic        e_csn, e_wen, last_g, g0, g1, st_now;
  logic [18:0] e_a;
  logic [15:0] e_din;
  int          ph, cyc, pass_cnt, tot_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
  endtask

  task automatic model_reset();
    e_csn = 1'b1; e_wen = 1'b0; e_a = '0; e_din = '0;
    rq.delete(); last_g = 1'b1; ph = 0; g0 = 1'b0; g1 = 1'b0; st_now = 1'b0;
  endtask

  // one cycle: inputs were just driven at the falling edge
  task automatic step();
    logic x0, x1, erv0, erv1, p;
    logic [15:0] er0, er1;
    #1;
    x0 = 1'b0; x1 = 1'b0;
    if (ph == 0 && !store_req) begin
      if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
        if (last_g) x0 = 1'b1; else x1 = 1'b1;
`else
        x0 = 1'b1;
`endif
      end else begin
        x0 = m0_req; x1 = m1_req;
      end
    end
    erv0 = 1'b0; erv1 = 1'b0; er0 = '0; er1 = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].p) begin erv1 = 1'b1; er1 = rq[0].d; end
      else         begin erv0 = 1'b1; er0 = rq[0].d; end
      void'(rq.pop_front());
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(x0));
    chk("m1_gnt", 32'(m1_gnt), 32'(x1));
    chk("csn", 32'(sram_csn), 32'(e_csn));
    chk("wen", 32'(sram_wen), 32'(e_wen));
    chk("addr", 32'(sram_a), 32'(e_a));
    chk("din", 32'(sram_din), 32'(e_din));
    chk("store", 32'(sram_store), 32'(ph == 2));
    chk("done", 32'(store_done), 32'(ph == 2));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(erv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(erv1));
    chk("m0_rdata", 32'(m0_rdata), 32'(er0));
    chk("m1_rdata", 32'(m1_rdata), 32'(er1));
    g0 = x0; g1 = x1; st_now = (ph == 2);
    if (x0 || x1) begin
      p = x1;
      e_csn = 1'b0;
      e_wen = p ? m1_we : m0_we;
      e_a   = p ? m1_addr : m0_addr;
      e_din = p ? m1_wdata : m0_wdata;
      if (e_wen) gmem[e_a] = e_din;
      else       rq.push_back('{due: cyc + 2, p: p, d: gmem[e_a]});
      last_g = p;
    end else begin
      e_csn = 1'b1; e_wen = 1'b0;
    end
    case (ph)
      0:       if (store_req) ph = 1;
      1:       ph = 2;
      default: ph = 0;
    endcase
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive0(input logic r, input logic w, input logic [18:0] a, input logic [15:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask
  task automatic drive1(input logic r, input logic w, input logic [18:0] a, input logic [15:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask

  // step n cycles, dropping each request once it is granted
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (g0) m0_req = 1'b0;
      if (g1) m1_req = 1'b0;
    end
  endtask

  function automatic logic [18:0] rnd_addr();
    return ($urandom % 4 == 0) ? 19'h7FFFF : 19'($urandom % 16);
  endfunction

  initial begin
    pass_cnt = 0; tot_cnt = 0; cyc = 0;
    for (int i = 0; i < 524288; i++) gmem[i] = '0;
    rst = 1'b1; store_req = 1'b0;
    drive0(0, 0, '0, '0); drive1(0, 0, '0, '0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_csn", 32'(sram_csn), 32'd1);
    chk("rst_a", 32'(sram_a), 32'd0);
    chk("rst_store", 32'(sram_store), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // known contents for every address the bench will read
    for (int i = 0; i < 17; i++) begin
      drive0(1, 1, (i == 16) ? 19'h7FFFF : 19'(i), 16'(16'hA000 + i));
      run(1);
    end
    drive0(1, 1, 19'h00010, 16'hBEEF); run(1);
    drive0(0, 0, '0, '0); run(2);

    // single read
    drive0(1, 0, 19'h00010, 16'h0); run(4);

    // m1 write then read of the same address
    drive1(1, 1, 19'h7FFFF, 16'h1234); run(1);
    drive1(1, 0, 19'h7FFFF, 16'h0);    run(4);

    // sustained conflict
    drive0(1, 0, 19'h1, '0); drive1(1, 0, 19'h2, '0);
    for (int i = 0; i < 6; i++) step();
    drive0(0, 0, '0, '0); drive1(0, 0, '0, '0); run(3);

    // store drain behind a write, with m1 waiting
    drive0(1, 1, 19'h3, 16'h5555); run(1);
    store_req = 1'b1; drive1(1, 0, 19'h5, '0);
    run(3);
    store_req = 1'b0;
    run(4);
    chk("dump3", 32'(dump3), 32'h5555);

    // idle hold
    run(10);

    // reset while a read is in flight
    drive0(1, 0, 19'h00010, '0); run(1);
    drive1(1, 0, 19'h4, '0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_gnt1", 32'(m1_gnt), 32'd0);
    chk("mrst_csn", 32'(sram_csn), 32'd1);
    chk("mrst_wen", 32'(sram_wen), 32'd0);
    chk("mrst_a", 32'(sram_a), 32'd0);
    chk("mrst_din", 32'(sram_din), 32'd0);
    chk("mrst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    @(negedge clk);
    rst = 1'b0; model_reset();
    drive1(0, 0, '0, '0);
    run(4);
    drive0(1, 0, 19'h1, '0); drive1(1, 0, 19'h2, '0);
    run(1);
    chk("post_rst_first_m0", 32'(g0), 32'd1);
    run(4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!m0_req || g0) drive0(1'($urandom % 3 != 0), 1'($urandom % 2), rnd_addr(), 16'($urandom));
      if (!m1_req || g1) drive1(1'($urandom % 3 != 0), 1'($urandom % 2), rnd_addr(), 16'($urandom));
      if (store_req && st_now) store_req = 1'b0;
      else if (!store_req)     store_req = 1'($urandom % 25 == 0);
      step();
    end
    drive0(0, 0, '0, '0); drive1(0, 0, '0, '0); store_req = 1'b0;
    run(5);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/sram_arb.md
# sram_arb

Two-port arbiter and sequencer for the 512K×16 image SRAM. It shares the single SRAM port between two requesters, for example an image-processing pipe and a host/DMA port. It issues one registered SRAM access per cycle and returns read data with a fixed latency. It also sequences the SRAM `store` dump so the dump only happens after all in-flight writes have landed. It sits directly between the requesters and the SRAM instance.

## Interface
Parameters:
- `AW`, default 19: SRAM address width (bits [18:0]).
- `DW`, default 16: data width.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge; shared with the SRAM.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `m0_req`, `m1_req`: input, 1 bit each. Access request, held until granted.
- `m0_we`, `m1_we`: input, 1 bit each. 1 = write, 0 = read.
- `m0_addr`, `m1_addr`: input, AW bits each. Access address.
- `m0_wdata`, `m1_wdata`: input, DW bits each. Write data.
- `m0_gnt`, `m1_gnt`: output, 1 bit each. Combinational grant; the access is accepted at the edge where `req` and `gnt` are both 1.
- `m0_rvalid`, `m1_rvalid`: output, 1 bit each. One-cycle pulse; read data is valid.
- `m0_rdata`, `m1_rdata`: output, DW bits each. Equal to `sram_dout` while the matching `rvalid` is 1, otherwise 0.
- `store_req`: input, 1 bit. Level request for an image dump, held until `store_done`.
- `store_done`: output, 1 bit. One-cycle pulse, coincident with `sram_store`.
- `sram_csn`: output, 1 bit. Active-low chip select, registered.
- `sram_wen`: output, 1 bit. Active-high write enable, registered.
- `sram_a`: output, AW bits. Registered address.
- `sram_din`: output, DW bits. Registered write data.
- `sram_dout`: input, DW bits. SRAM read data; valid one cycle after the access edge.
- `sram_store`: output, 1 bit. Registered one-cycle dump strobe.

## Operation
- FSM states: ARB, DRAIN, STORE.
- ARB:
  - At most one grant per cycle.
  - With no request, both grants are 0.
  - If both ports request, the arbitration policy decides (see Configuration).
  - An accepted request loads the command register: `sram_csn`=0, `sram_wen`=`we`, `sram_a`=`addr`, `sram_din`=`wdata`.
  - With no accepted request, `sram_csn`=1, `sram_wen`=0, and `sram_a`/`sram_din` hold their values.
- Read tracking: a 2-stage shift of {valid, port id} follows each accepted read. The owning `rvalid` pulses in the second cycle after acceptance. Writes never produce `rvalid`.
- ARB→DRAIN:
  - Taken when `store_req`=1 is sampled in ARB.
  - In the ARB cycle where `store_req`=1, both grants are 0; `store_req` has priority over any request.
- DRAIN:
  - No grants are issued.
  - The FSM waits until the command register is idle (`sram_csn`=1), then moves to STORE.
  - A write issued just before the store request therefore lands before the dump.
  - Outstanding reads still complete in DRAIN.
- STORE: one cycle with `sram_store`=1 and `store_done`=1, then return to ARB.
- `store_req` sampled again in the cycle after `store_done` starts a new dump; the requester drops it on `store_done`.
- Reset:
  - Clears the FSM to ARB and the round-robin pointer to "m0 first".
  - Clears the read shift, so in-flight reads are dropped and never return `rvalid`.
  - Forces idle outputs.
- Reset values: `sram_csn`=1, `sram_wen`=0, `sram_a`=0, `sram_din`=0, `sram_store`=0, `store_done`=0, all `gnt`=0, all `rvalid`=0, all `rdata`=0.

## Timing
- Throughput: one access per cycle, with back-to-back grants allowed to either port.
- Cycle N: `req`&`gnt` is sampled at edge E0.
- Cycle N+1: the SRAM pins carry the command; the SRAM captures it at E1.
- Cycle N+2: `rvalid`=1 and `rdata`=`sram_dout` (read-to-data latency 2 cycles).
- A write at edge E1 is visible to a read accepted in cycle N+1 or later.
- Store latency from `store_req` rising in ARB:
  - 2 cycles to `sram_store` if the command register is busy (DRAIN, then STORE).
  - Exactly 2 cycles if it was already idle: DRAIN lasts one cycle, then STORE.

## Configuration
- `SRAM_ARB_RR_EN` defined:
  - Round-robin arbitration. On conflict, the port not granted most recently wins.
  - The pointer updates only on an accepted grant.
  - The reset pointer favours m0.
- `SRAM_ARB_RR_EN` undefined:
  - Fixed priority: m0 always wins a conflict, and m1 can starve.
  - The pointer logic is absent.

## Test plan
- Single read: preload addr 0x00010=0xBEEF; m0 read at cycle 5 → `sram_csn`=0, `sram_a`=0x00010 in cycle 6; `m0_rvalid`=1 with `m0_rdata`=0xBEEF in cycle 7 only.
- Write-then-read: m1 writes 0x1234 to 0x7FFFF, then m1 reads the same address on the next cycle → `m1_rdata`=0x1234, and `m0_rvalid` stays 0 throughout.
- Conflict: m0 and m1 request continuously for 6 cycles → grant order 0,1,0,1,0,1 with RR_EN; 0,0,0,0,0,0 without it.
- Store drain: m0 write 0x5555 to 0x00003 accepted, with `store_req` rising the next cycle → no grants until `store_done`; `sram_store` pulses exactly once, after the write cycle; the dumped image has 0x5555 at address 3.
- Reset mid-read: assert `rst` in the cycle after a read is accepted → all outputs take their reset values immediately; no `rvalid` after release; the first conflict after reset goes to m0.
- Idle: no requests for 10 cycles → `sram_csn`=1, `sram_wen`=0, and `sram_a`/`sram_din` unchanged.
